// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
package pipe_ctrl_pkg;

  // Stored destination width; must be >= the controller's REG_W.
  localparam int unsigned WSEL_W = 8;

  // Forward select value meaning "use the regfile / ID/EX latched operand".
  localparam int unsigned FWD_RF = 0;

  // One in-flight instruction's destination info.
  typedef struct packed {
    logic              valid;
    logic [WSEL_W-1:0] wsel;
    logic              wen;
    logic              load;
  } sb_entry_t;

  // Width of one forward select field for a given scoreboard depth.
  function automatic int unsigned fwd_sel_w(input int unsigned stages);
    return 32'($clog2(stages + 1));
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Destination scoreboard for in-flight instructions plus ID-source readiness compare.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned REG_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic                  bubble,
  input  logic                  id_valid,
  input  logic [NSRC*REG_W-1:0] id_rsel,
  input  logic [NSRC-1:0]       id_ruse,
  input  logic [REG_W-1:0]      id_wsel,
  input  logic                  id_wen,
  input  logic                  id_load,
  input  logic                  id_branch,
  output sb_entry_t [STAGES:1]  entry,
  output logic [NSRC*REG_W-1:0] ex_rsel,
  output logic [NSRC-1:0]       ex_ruse,
  output logic                  hazard
);

  int unsigned ready_d;

  // Shift entries down the pipe on advance; depth 1 takes ID info or a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry   <= '0;
      ex_rsel <= '0;
      ex_ruse <= '0;
    end else if (advance) begin
      for (int unsigned k = STAGES; k >= 2; k--) begin
        entry[k] <= entry[k-1];
      end
      if (bubble) begin
        entry[1] <= '0;
        ex_rsel  <= '0;
        ex_ruse  <= '0;
      end else begin
        entry[1].valid <= 1'b1;
        entry[1].wsel  <= WSEL_W'(id_wsel);
        entry[1].wen   <= id_wen;
        entry[1].load  <= id_load;
        ex_rsel        <= id_rsel;
        ex_ruse        <= id_ruse;
      end
    end
  end

  // A producer at depth k blocks ID until it reaches its ready depth.
  always_comb begin
    hazard  = 1'b0;
    ready_d = 32'd1;
    for (int unsigned k = 1; k <= STAGES; k++) begin
      ready_d = (entry[k].load ? LOAD_LAT : 32'd1) + 32'(id_branch);
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (entry[k].valid && entry[k].wen && (entry[k].wsel != '0) &&
            (entry[k].wsel == WSEL_W'(id_rsel[i*REG_W +: REG_W])) &&
            id_ruse[i] && id_valid && (k < ready_d)) begin
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock/forwarding controller for the in-order MIPS pipeline.
// Optional PIPE_HAZARD_PERF_EN adds saturating stall/flush/freeze cycle counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned  STAGES   = 3,
  parameter int unsigned  LOAD_LAT = 2,
  parameter int unsigned  NSRC     = 2,
  parameter int unsigned  REG_W    = 5,
  localparam int unsigned FW       = fwd_sel_w(STAGES)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  if_ready,
  input  logic                  mem_busy,
  input  logic                  id_valid,
  input  logic [NSRC*REG_W-1:0] id_rsel,
  input  logic [NSRC-1:0]       id_ruse,
  input  logic [REG_W-1:0]      id_wsel,
  input  logic                  id_wen,
  input  logic                  id_load,
  input  logic                  id_branch,
  input  logic                  redirect,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_flush,
  output logic                  stage_en,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt,
  output logic [31:0]           freeze_cnt,
`endif
  output logic [NSRC*FW-1:0]    fwd_sel
);

  sb_entry_t [STAGES:1]  entry;
  logic [NSRC*REG_W-1:0] ex_rsel;
  logic [NSRC-1:0]       ex_ruse;
  logic                  hazard;

  pipe_scoreboard #(
    .STAGES  (STAGES),
    .LOAD_LAT(LOAD_LAT),
    .NSRC    (NSRC),
    .REG_W   (REG_W)
  ) u_sb (
    .clk      (CLK),
    .rst      (RST),
    .advance  (!mem_busy),
    .bubble   (hazard || !id_valid),
    .id_valid (id_valid),
    .id_rsel  (id_rsel),
    .id_ruse  (id_ruse),
    .id_wsel  (id_wsel),
    .id_wen   (id_wen),
    .id_load  (id_load),
    .id_branch(id_branch),
    .entry    (entry),
    .ex_rsel  (ex_rsel),
    .ex_ruse  (ex_ruse),
    .hazard   (hazard)
  );

  // Priority decode: freeze > stall > redirect > fetch miss > normal.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    stage_en   = 1'b1;
    if (mem_busy) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      stage_en = 1'b0;
    end else if (hazard) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (redirect) begin
      ifid_flush = 1'b1;
    end else if (!if_ready) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // Per EX source: youngest matching producer at depth >= 2, else regfile.
  always_comb begin
    for (int unsigned i = 0; i < NSRC; i++) begin
      fwd_sel[i*FW +: FW] = FW'(FWD_RF);
      for (int unsigned j = STAGES; j >= 2; j--) begin
        if (entry[j].valid && entry[j].wen && (entry[j].wsel != '0) &&
            (entry[j].wsel == WSEL_W'(ex_rsel[i*REG_W +: REG_W])) && ex_ruse[i]) begin
          fwd_sel[i*FW +: FW] = FW'(j);
        end
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic freeze_act;
  logic stall_act;
  logic flush_act;

  assign freeze_act = mem_busy;
  assign stall_act  = !mem_busy && hazard;
  assign flush_act  = !mem_busy && !hazard && redirect;

  // Saturating cycle counters for each priority case.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall_act && (stall_cnt != '1))   stall_cnt  <= stall_cnt + 32'd1;
      if (flush_act && (flush_cnt != '1))   flush_cnt  <= flush_cnt + 32'd1;
      if (freeze_act && (freeze_cnt != '1)) freeze_cnt <= freeze_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (default 3-deep, load latency 2).
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned STAGES   = 3;
  localparam int unsigned LOAD_LAT = 2;
  localparam int unsigned NSRC     = 2;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned FW       = fwd_sel_w(STAGES);

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, stage_en}
  localparam logic [5:0] C_NORM    = 6'b110101;
  localparam logic [5:0] C_STALL   = 6'b000111;
  localparam logic [5:0] C_FRZ     = 6'b000000;
  localparam logic [5:0] C_REDIR   = 6'b111101;
  localparam logic [5:0] C_NOFETCH = 6'b011101;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic                  if_ready;
  logic                  mem_busy;
  logic                  id_valid;
  logic [NSRC*REG_W-1:0] id_rsel;
  logic [NSRC-1:0]       id_ruse;
  logic [REG_W-1:0]      id_wsel;
  logic                  id_wen;
  logic                  id_load;
  logic                  id_branch;
  logic                  redirect;
  logic                  pc_en;
  logic                  ifid_en;
  logic                  ifid_flush;
  logic                  idex_en;
  logic                  idex_flush;
  logic                  stage_en;
  logic [NSRC*FW-1:0]    fwd_sel;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]           stall_cnt;
  logic [31:0]           flush_cnt;
  logic [31:0]           freeze_cnt;
`endif

  typedef struct {
    string            tag;
    logic [5:0]       ctl;
    logic [NSRC*FW-1:0] fwd;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(
    .STAGES  (STAGES),
    .LOAD_LAT(LOAD_LAT),
    .NSRC    (NSRC),
    .REG_W   (REG_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .if_ready  (if_ready),
    .mem_busy  (mem_busy),
    .id_valid  (id_valid),
    .id_rsel   (id_rsel),
    .id_ruse   (id_ruse),
    .id_wsel   (id_wsel),
    .id_wen    (id_wen),
    .id_load   (id_load),
    .id_branch (id_branch),
    .redirect  (redirect),
    .pc_en     (pc_en),
    .ifid_en   (ifid_en),
    .ifid_flush(ifid_flush),
    .idex_en   (idex_en),
    .idex_flush(idex_flush),
    .stage_en  (stage_en),
`ifdef PIPE_HAZARD_PERF_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .freeze_cnt(freeze_cnt),
`endif
    .fwd_sel   (fwd_sel)
  );

  // Present an instruction in ID.
  task automatic id_instr(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                          input logic [1:0] ru, input logic [4:0] wd, input logic we,
                          input logic ld, input logic br);
    id_valid  = v;
    id_rsel   = {rs1, rs0};
    id_ruse   = ru;
    id_wsel   = wd;
    id_wen    = we;
    id_load   = ld;
    id_branch = br;
  endtask

  task automatic nop();
    id_instr(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Compare the oldest pending expectation against the DUT outputs.
  task automatic check_out();
    exp_t       e;
    logic [5:0] obs;
    e   = exp_q.pop_front();
    obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, stage_en};
    n_cmp++;
    assert (obs === e.ctl) else begin
      n_bad++;
      $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs, e.ctl);
    end
    n_cmp++;
    assert (fwd_sel === e.fwd) else begin
      n_bad++;
      $error("FAIL %s fwd_sel observed=%b expected=%b", e.tag, fwd_sel, e.fwd);
    end
  endtask

  // One cycle: inputs already driven at negedge; queue expectation, check, advance.
  task automatic step(input string tag, input logic [5:0] ctl, input logic [NSRC*FW-1:0] fwd);
    exp_t e;
    e.tag = tag;
    e.ctl = ctl;
    e.fwd = fwd;
    exp_q.push_back(e);
    #1;
    check_out();
    @(negedge CLK);
  endtask

  task automatic drain(input string tag);
    nop();
    for (int n = 0; n < 3; n++) step(tag, C_NORM, 4'b0000);
  endtask

`ifdef PIPE_HAZARD_PERF_EN
  task automatic check_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask
`endif

  initial begin
    RST      = 1'b1;
    if_ready = 1'b1;
    mem_busy = 1'b0;
    redirect = 1'b0;
    nop();
    @(negedge CLK);
    @(negedge CLK);

    // Reset state
    step("rst_norm", C_NORM, 4'b0000);
    if_ready = 1'b0;
    step("rst_nofetch", C_NOFETCH, 4'b0000);
    if_ready = 1'b1;
`ifdef PIPE_HAZARD_PERF_EN
    check_cnt("rst_stall_cnt", stall_cnt, 32'd0);
    check_cnt("rst_freeze_cnt", freeze_cnt, 32'd0);
`endif
    RST = 1'b0;

    // 1: load-use, one stall then forward from depth 3
    id_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b1, 1'b0);
    step("t1_lw", C_NORM, 4'b0000);
    id_instr(1'b1, 5'd3, 5'd1, 2'b11, 5'd4, 1'b1, 1'b0, 1'b0);
    step("t1_stall", C_STALL, 4'b0000);
    step("t1_release", C_NORM, 4'b0000);
    nop();
    step("t1_fwd3", C_NORM, 4'b0011);
`ifdef PIPE_HAZARD_PERF_EN
    check_cnt("t1_stall_cnt", stall_cnt, 32'd1);
`endif

    // 2: ALU producer, no stall; youngest of two producers wins
    id_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0);
    step("t2_add_a", C_NORM, 4'b0000);
    step("t2_add_b", C_NORM, 4'b0000);
    id_instr(1'b1, 5'd4, 5'd4, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
    step("t2_sub_nostall", C_NORM, 4'b0000);
    nop();
    step("t2_fwd2", C_NORM, 4'b1010);
    drain("t2_drain");

    // 3a: branch in ID after ALU producer -> one stall
    id_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
    step("t3_add", C_NORM, 4'b0000);
    id_instr(1'b1, 5'd5, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1);
    step("t3_beq_stall", C_STALL, 4'b0000);
    step("t3_beq_go", C_NORM, 4'b0000);
    nop();
    step("t3_beq_fwd", C_NORM, 4'b0011);
    drain("t3_drain");

    // 3b: branch in ID after load -> two stalls
    id_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);
    step("t3_lw", C_NORM, 4'b0000);
    id_instr(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1);
    step("t3_lwbeq_s1", C_STALL, 4'b0000);
    step("t3_lwbeq_s2", C_STALL, 4'b0000);
    step("t3_lwbeq_go", C_NORM, 4'b0000);
    drain("t3b_drain");

    // 4: memory freeze during a load-use stall
    id_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b1, 1'b0);
    step("t4_lw", C_NORM, 4'b0000);
    id_instr(1'b1, 5'd3, 5'd1, 2'b11, 5'd4, 1'b1, 1'b0, 1'b0);
    mem_busy = 1'b1;
    for (int n = 0; n < 3; n++) step("t4_freeze", C_FRZ, 4'b0000);
    mem_busy = 1'b0;
    step("t4_stall", C_STALL, 4'b0000);
    step("t4_release", C_NORM, 4'b0000);
    nop();
    step("t4_fwd3", C_NORM, 4'b0011);
`ifdef PIPE_HAZARD_PERF_EN
    check_cnt("t4_freeze_cnt", freeze_cnt, 32'd3);
`endif
    drain("t4_drain");

    // 5: redirect alone, then redirect with a pending hazard
    id_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    redirect = 1'b1;
    step("t5_redir", C_REDIR, 4'b0000);
    redirect = 1'b0;
    id_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
    step("t5_lw", C_NORM, 4'b0000);
    id_instr(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1);
    redirect = 1'b1;
    step("t5_hz_s1", C_STALL, 4'b0000);
    step("t5_hz_s2", C_STALL, 4'b0000);
    step("t5_hz_redir", C_REDIR, 4'b0000);
    redirect = 1'b0;
    nop();
    if_ready = 1'b0;
    step("t5_nofetch", C_NOFETCH, 4'b0000);
    if_ready = 1'b1;
`ifdef PIPE_HAZARD_PERF_EN
    check_cnt("t5_flush_cnt", flush_cnt, 32'd2);
`endif
    drain("t5_drain");

    // 6: producer writing r0 never stalls or forwards
    id_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b0);
    step("t6_lw_r0", C_NORM, 4'b0000);
    id_instr(1'b1, 5'd0, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b0);
    step("t6_use_r0", C_NORM, 4'b0000);
    nop();
    step("t6_fwd_r0", C_NORM, 4'b0000);
    drain("t6_drain");

    // 7: reset asserted in the first of two stall cycles
    id_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0);
    step("t7_add", C_NORM, 4'b0000);
    id_instr(1'b1, 5'd4, 5'd0, 2'b01, 5'd3, 1'b1, 1'b1, 1'b0);
    step("t7_lw", C_NORM, 4'b0000);
    id_instr(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1);
    RST = 1'b1;
    step("t7_stall_rst", C_STALL, 4'b0010);
    step("t7_after_rst", C_NORM, 4'b0000);
    RST = 1'b0;
    step("t7_resume", C_NORM, 4'b0000);
    nop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
